// File: rtl/inst_fifo.sv
// inst_fifo: dual-port instruction queue between fetch and dual-issue decode.
// Takes up to two compacted fetch slots per cycle and retires one or two head
// entries per cycle. Head and head+1 are presented combinationally. An early
// full flag gives fetch headroom, and a sticky overflow flag records dropped
// pushes.
module inst_fifo #(
    parameter int DEPTH      = 16,
    parameter int FULL_SLACK = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush_i,
    input  logic                     push_stall_i,
    input  logic                     pop_stall_i,
    input  logic [31:0]              inst1_i,
    input  logic [31:0]              inst2_i,
    input  logic [31:0]              inst1_addr_i,
    input  logic [31:0]              inst2_addr_i,
    input  logic                     inst1_valid_i,
    input  logic                     inst2_valid_i,
    input  logic                     issue_i,
    input  logic                     issue_mode_i,
    output logic [31:0]              issue_inst1_o,
    output logic [31:0]              issue_inst2_o,
    output logic [31:0]              issue_inst1_addr_o,
    output logic [31:0]              issue_inst2_addr_o,
    output logic                     issue_inst1_valid_o,
    output logic                     issue_inst2_valid_o,
    output logic                     buffer_full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    // Pointer and occupancy state.
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          overflow_reg, overflow_next;

    // Per-cycle push/pop bookkeeping.
    logic [1:0]    npush_req;
    logic [1:0]    pop_req;
    logic [1:0]    npop;
    logic [1:0]    npush_acc;
    logic [CW:0]   free_slots;
    logic          push_drop;

    // Write ports: slot A takes the first valid instruction, slot B the second.
    logic          wa_en, wb_en;
    logic [AW-1:0] wa_addr, wb_addr;
    entry_t        wa_data, wb_data;

    // Storage, one register per entry, gathered for read muxing.
    entry_t        entry_q [DEPTH];
    logic [AW-1:0] rd_ptr_p1;
    entry_t        head0, head1;

    // Requested push/pop amounts, pop clamp, capacity and accepted pushes.
    always_comb begin
        npush_req = 2'd0;
        if (!push_stall_i) begin
            npush_req = {1'b0, inst1_valid_i} + {1'b0, inst2_valid_i};
        end

        pop_req = 2'd0;
        if (issue_i && !pop_stall_i) begin
            pop_req = issue_mode_i ? 2'd2 : 2'd1;
        end

        // Never pop more than is stored; count < 2 fits in two bits here.
        if (count_reg >= CW'(pop_req)) begin
            npop = pop_req;
        end else begin
            npop = count_reg[1:0];
        end

        // Slots freed by this cycle's pop are reusable by this cycle's push.
        free_slots = (CW+1)'(DEPTH) - {1'b0, count_reg} + (CW+1)'(npop);

        // Excess slots are dropped in order, so inst2 goes first.
        if ((CW+1)'(npush_req) <= free_slots) begin
            npush_acc = npush_req;
        end else begin
            npush_acc = free_slots[1:0];
        end

        push_drop = (npush_acc != npush_req) && !flush_i;
    end

    // Compaction of the two fetch slots onto consecutive tail locations.
    always_comb begin
        wa_addr      = wr_ptr_reg;
        wb_addr      = wr_ptr_reg + 1'b1;
        wa_data.inst = inst1_valid_i ? inst1_i      : inst2_i;
        wa_data.pc   = inst1_valid_i ? inst1_addr_i : inst2_addr_i;
        wb_data.inst = inst2_i;
        wb_data.pc   = inst2_addr_i;
        wa_en        = !flush_i && (npush_acc != 2'd0);
        wb_en        = !flush_i && (npush_acc == 2'd2);
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        if (flush_i) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            rd_ptr_next = rd_ptr_reg + AW'(npop);
            wr_ptr_next = wr_ptr_reg + AW'(npush_acc);
            count_next  = count_reg + CW'(npush_acc) - CW'(npop);
        end
        overflow_next = overflow_reg | push_drop;
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // One storage register per entry; contents are never cleared, only the
    // pointers decide what is live.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            entry_t entry_reg;

            // Capture from whichever write port targets this slot.
            always_ff @(posedge clk) begin
                if (wa_en && (wa_addr == AW'(gi))) begin
                    entry_reg <= wa_data;
                end else if (wb_en && (wb_addr == AW'(gi))) begin
                    entry_reg <= wb_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Head and head+1 reads, with pointer wrap.
    always_comb begin
        rd_ptr_p1 = rd_ptr_reg + 1'b1;
        head0     = entry_q[rd_ptr_reg];
        head1     = entry_q[rd_ptr_p1];
    end

    // Status flags depend only on the registered count.
    always_comb begin
        issue_inst1_valid_o = (count_reg != '0);
        issue_inst2_valid_o = (count_reg >= CW'(2));
        buffer_full_o       = (count_reg > CW'(DEPTH - FULL_SLACK));
        count_o             = count_reg;
        overflow_o          = overflow_reg;
    end

    // Issue data, forced to zero for invalid positions.
    always_comb begin
        issue_inst1_o      = issue_inst1_valid_o ? head0.inst : 32'd0;
        issue_inst1_addr_o = issue_inst1_valid_o ? head0.pc   : 32'd0;
        issue_inst2_o      = issue_inst2_valid_o ? head1.inst : 32'd0;
        issue_inst2_addr_o = issue_inst2_valid_o ? head1.pc   : 32'd0;
    end

endmodule
